// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial add sequencer.
// The optional subtract mode of serial_adder_ctrl is enabled by SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Bit-counter width: enough to index bits 0..width-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, shared by the serial add sequencer.
module full_adder (
   input  logic bit1,
   input  logic bit2,
   input  logic carry_in,
   output logic result,
   output logic carry_out
);

   logic half_sum;

   assign half_sum  = bit1 ^ bit2;
   assign result    = half_sum ^ carry_in;
   assign carry_out = (bit1 & bit2) | (carry_in & half_sum);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: one full_adder, one bit pair per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' input (a - b with carry_out = no borrow).
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int unsigned    CntW    = cnt_w(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             carry_q, carry_d;
   logic             carry_out_q, carry_out_d;

   logic             accept;
   logic             run;
   logic             last_bit;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;
   logic             fa_sum;
   logic             fa_carry;

   assign accept   = (state_q == StIdle) && start;
   assign run      = (state_q == StRun);
   assign last_bit = run && (count_q == LastCnt);

`ifdef SERIAL_ADDER_SUB_EN
   // Subtract as a + ~b + 1; the forced carry overrides carry_in.
   assign b_load     = sub ? ~operand_b : operand_b;
   assign carry_load = sub | carry_in;
`else
   assign b_load     = operand_b;
   assign carry_load = carry_in;
`endif

   full_adder u_full_adder (
      .bit1      (a_sh_q[0]),
      .bit2      (b_sh_q[0]),
      .carry_in  (carry_q),
      .result    (fa_sum),
      .carry_out (fa_carry)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (count_q == LastCnt) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         StRun:   busy = 1'b1;
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state
   always_comb begin
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      sum_d       = sum_q;
      count_d     = count_q;
      carry_d     = carry_q;
      carry_out_d = carry_out_q;
      if (accept) begin
         a_sh_d  = operand_a;
         b_sh_d  = b_load;
         carry_d = carry_load;
         count_d = '0;
      end else if (run) begin
         // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at sum[0].
         sum_d            = sum_q >> 1;
         sum_d[WIDTH-1]   = fa_sum;
         a_sh_d           = a_sh_q >> 1;
         b_sh_d           = b_sh_q >> 1;
         carry_d          = fa_carry;
         count_d          = count_q + CntW'(1);
         if (last_bit) begin
            carry_out_d = fa_carry;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         sum_q       <= '0;
         count_q     <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
      end else begin
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         sum_q       <= sum_d;
         count_q     <= count_d;
         carry_q     <= carry_d;
         carry_out_q <= carry_out_d;
      end
   end

   assign sum       = sum_q;
   assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8); exercises subtract mode when
// SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

   localparam int unsigned W = 8;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;
   logic         carry_in;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry_out;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   serial_adder_ctrl #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .carry_in  (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub),
`endif
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sb;
      logic [W-1:0] exp_sum;
      logic         exp_co;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sb);
      int unsigned r;
      if (sb) r = int'(a) + ((1 << W) - 1 - int'(b)) + 1;
      else    r = int'(a) + int'(b) + int'(cin);
      return (W + 1)'(r);
   endfunction

   // Issue one op from an IDLE negedge and check latency, result and done pulse width.
   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sb,
                         input logic [W-1:0] exp_sum, input logic exp_co);
      int n;
      operand_a = a;
      operand_b = b;
      carry_in  = cin;
      sub       = sb;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, "_busy"}, 32'(busy), 32'd1);
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, "_latency"}, 32'(n), 32'(W));
      check({name, "_sum"}, 32'(sum), 32'(exp_sum));
      check({name, "_co"}, 32'(carry_out), 32'(exp_co));
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic [W:0]   r;
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      int           n, dcnt, t1, t2;

      reset     = 1'b1;
      start     = 1'b0;
      operand_a = '0;
      operand_b = '0;
      carry_in  = 1'b0;
      sub       = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_co", 32'(carry_out), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      vecs.push_back('{a: 8'h35, b: 8'h4A, cin: 1'b0, sb: 1'b0, exp_sum: 8'h7F, exp_co: 1'b0});
      vecs.push_back('{a: 8'hFF, b: 8'h01, cin: 1'b0, sb: 1'b0, exp_sum: 8'h00, exp_co: 1'b1});
      vecs.push_back('{a: 8'hFF, b: 8'hFF, cin: 1'b1, sb: 1'b0, exp_sum: 8'hFF, exp_co: 1'b1});
      vecs.push_back('{a: 8'h00, b: 8'h00, cin: 1'b1, sb: 1'b0, exp_sum: 8'h01, exp_co: 1'b0});
      vecs.push_back('{a: 8'hAA, b: 8'h55, cin: 1'b0, sb: 1'b0, exp_sum: 8'hFF, exp_co: 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
      vecs.push_back('{a: 8'h05, b: 8'h07, cin: 1'b0, sb: 1'b1, exp_sum: 8'hFE, exp_co: 1'b0});
      vecs.push_back('{a: 8'h07, b: 8'h05, cin: 1'b0, sb: 1'b1, exp_sum: 8'h02, exp_co: 1'b1});
      vecs.push_back('{a: 8'h07, b: 8'h07, cin: 1'b0, sb: 1'b1, exp_sum: 8'h00, exp_co: 1'b1});
`endif
      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb,
                vecs[i].exp_sum, vecs[i].exp_co);
      end

      // Start pulses during RUN/DONE with other operands must be ignored.
      operand_a = 8'h12;
      operand_b = 8'h34;
      carry_in  = 1'b0;
      sub       = 1'b0;
      start     = 1'b1;
      @(negedge clk);
      dcnt = 0;
      n    = 0;
      while (!done && n < 40) begin
         start     = 1'b1;
         operand_a = W'($urandom);
         operand_b = W'($urandom);
         carry_in  = 1'($urandom);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (done) dcnt++;
      check("ignore_sum", 32'(sum), 32'h46);
      check("ignore_co", 32'(carry_out), 32'd0);
      repeat (12) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("ignore_done_count", 32'(dcnt), 32'd1);

      // Reset in the 4th RUN cycle aborts with no done.
      operand_a = 8'hFF;
      operand_b = 8'h00;
      carry_in  = 1'b0;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_co", 32'(carry_out), 32'd0);
      reset = 1'b0;
      dcnt  = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("abort_no_done", 32'(dcnt), 32'd0);
      run_op("after_abort", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);

      // Back-to-back with start held high.
      operand_a = 8'h10;
      operand_b = 8'h20;
      carry_in  = 1'b0;
      start     = 1'b1;
      n = 0;
      @(negedge clk);
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      t1 = cyc;
      check("b2b_sum1", 32'(sum), 32'h30);
      check("b2b_co1", 32'(carry_out), 32'd0);
      operand_a = 8'h80;
      operand_b = 8'h80;
      n = 0;
      @(negedge clk);
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      t2    = cyc;
      start = 1'b0;
      check("b2b_sum2", 32'(sum), 32'h00);
      check("b2b_co2", 32'(carry_out), 32'd1);
      check("b2b_spacing", 32'(t2 - t1), 32'(W + 2));
      @(negedge clk);
      check("b2b_done_pulse", 32'(done), 32'd0);

      // Randomized ops against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         r = model(ra, rb, rc, rs);
         run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, r[W-1:0], r[W]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
